// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path:
//   - FSM state encoding
//   - opcode / funct constants
//   - pc_src and alu_src_b encodings
//   - instruction legality helpers
// Optional feature macro: BRANCH_EXT_EN enables blez, bgtz, bltz and bgez.
// Without it, those opcodes are treated as undecodable.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] FN_JR     = 6'h08;

  // Opcode presented to the ALU for PC+4 and branch-target adds.
  localparam logic [5:0] ALU_OP_ADDU = 6'h09;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG_A  = 2'd3;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

`ifdef BRANCH_EXT_EN
  localparam bit BRANCH_EXT = 1'b1;
`else
  localparam bit BRANCH_EXT = 1'b0;
`endif

  function automatic logic funct_supported(input logic [5:0] funct);
    return funct inside {6'h00, [6'h02:6'h04], [6'h06:6'h08],
                         [6'h20:6'h27], 6'h2a, 6'h2b};
  endfunction

  // I-type ALU ops occupy 0x08..0x0f.
  function automatic logic is_itype_alu(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] funct,
                                    input logic [4:0] rt);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE:           ok = funct_supported(funct);
      OP_J, OP_BEQ, OP_BNE,
      OP_LW, OP_SW:       ok = 1'b1;
      OP_BLEZ, OP_BGTZ:   ok = BRANCH_EXT;
      OP_REGIMM:          ok = BRANCH_EXT && (rt < 5'd2);
      default:            ok = is_itype_alu(op);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_branch_eval.sv
// mips_branch_eval
// Combinational branch-condition evaluation.
// Ports:
//   op, rt                         - instruction fields selecting the condition
//   gtz, ne, eq, gez, lez, ltz     - ALU compare flags
//   taken                          - branch condition true
// Extended branches (blez/bgtz/bltz/bgez) only resolve when BRANCH_EXT_EN
// is defined; otherwise they never report taken.
module mips_branch_eval
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic       gtz,
  input  logic       ne,
  input  logic       eq,
  input  logic       gez,
  input  logic       lez,
  input  logic       ltz,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:    taken = eq;
      OP_BNE:    taken = ne;
      OP_BLEZ:   taken = BRANCH_EXT && lez;
      OP_BGTZ:   taken = BRANCH_EXT && gtz;
      // REGIMM: rt=0 is bltz, rt=1 is bgez; other rt values never reach EXEC.
      OP_REGIMM: taken = BRANCH_EXT && ((rt == 5'd0) ? ltz : ((rt == 5'd1) && gez));
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle MIPS control FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB.
// Outputs are decoded from the current state and the live op/funct/rt
// fields; FETCH and MEM also react to mem_ack in the same cycle.
// Ports:
//   clk, rst_n (async, active-low)
//   op, funct, rt            - instruction fields
//   gtz..ltz                 - ALU compare flags for branches
//   mem_ack                  - memory transfer complete
//   mem_req, mem_we, iord    - memory interface control
//   ir_write, pc_write, pc_src
//   alu_opcode, alu_funct, alu_src_a, alu_src_b
//   reg_write, reg_dst, mem_to_reg
//   illegal                  - one-cycle pulse for undecodable instructions
// Optional feature macro: BRANCH_EXT_EN (extended branches).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       gtz,
  input  logic       ne,
  input  logic       eq,
  input  logic       gez,
  input  logic       lez,
  input  logic       ltz,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [5:0] alu_opcode,
  output logic [5:0] alu_funct,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);

  state_t state_reg, state_next;
  logic   branch_taken;

  mips_branch_eval u_branch_eval (
    .op    (op),
    .rt    (rt),
    .gtz   (gtz),
    .ne    (ne),
    .eq    (eq),
    .gez   (gez),
    .lez   (lez),
    .ltz   (ltz),
    .taken (branch_taken)
  );

  // Reset drops straight to IDLE, whose decode is all zeros, so outputs
  // clear without waiting for an edge and any in-flight transfer is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_opcode = 6'h00;
    alu_funct  = 6'h00;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        alu_opcode = ALU_OP_ADDU;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_ALU;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b  = SRC_B_IMM_SH2;
        alu_opcode = ALU_OP_ADDU;
        if (op == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          state_next = FETCH;
        end else if (!op_legal(op, funct, rt)) begin
          illegal    = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (op == OP_RTYPE && funct == FN_JR) begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_REG_A;
          state_next = FETCH;
        end else if (op == OP_RTYPE) begin
          alu_opcode = op;
          alu_funct  = funct;
          alu_src_b  = SRC_B_REG;
          state_next = WB;
        end else if (is_itype_alu(op)) begin
          alu_opcode = op;
          alu_src_b  = SRC_B_IMM;
          state_next = WB;
        end else if (op == OP_LW || op == OP_SW) begin
          alu_opcode = op;
          alu_src_b  = SRC_B_IMM;
          state_next = MEM;
        end else begin
          // Only legal branches remain at this point.
          alu_opcode = op;
          alu_src_b  = SRC_B_REG;
          pc_src     = PC_SRC_ALUOUT;
          pc_write   = branch_taken;
          state_next = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ack) state_next = (op == OP_SW) ? FETCH : WB;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = (op == OP_LW);
        state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Drives directed and random instruction streams into mips_multicycle_ctrl.
// A per-instruction model expands each instruction into its expected
// cycle-by-cycle output vectors (with chosen memory wait counts), and every
// cycle's outputs are compared against it.
module tb_mips_multicycle_ctrl;

`ifdef BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic [4:0] rt = '0;
  logic       gtz = 0, ne = 0, eq = 0, gez = 0, lez = 0, ltz = 0;
  logic       mem_ack = 0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_opcode, alu_funct;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [25:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  logic        q_ack[$];
  logic [5:0]  q_fl[$];
  logic [25:0] q_exp[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rt(rt),
    .gtz(gtz), .ne(ne), .eq(eq), .gez(gez), .lez(lez), .ltz(ltz),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_opcode,
                alu_funct, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal};

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (op=%h funct=%h rt=%0d)", tag, got, exp, op, funct, rt);
    end
  endtask

  function automatic logic [25:0] ov(
      input logic mreq, input logic mwe, input logic io, input logic irw,
      input logic pcw, input logic [1:0] pcs, input logic [5:0] opc,
      input logic [5:0] fn, input logic sa, input logic [1:0] sb,
      input logic rw, input logic rd, input logic m2r, input logic ill);
    return {mreq, mwe, io, irw, pcw, pcs, opc, fn, sa, sb, rw, rd, m2r, ill};
  endfunction

  // Instruction rules written directly from the opcode table.
  function automatic bit m_legal(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    int ok_fn[17] = '{0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    if (o == 6'd0) begin
      foreach (ok_fn[i]) if (int'(f) == ok_fn[i]) return 1'b1;
      return 1'b0;
    end
    if (o == 6'd2 || o == 6'd4 || o == 6'd5 || o == 6'h23 || o == 6'h2b) return 1'b1;
    if (o >= 6'd8 && o <= 6'd15) return 1'b1;
    if (o == 6'd6 || o == 6'd7) return EXT;
    if (o == 6'd1) return EXT && (r == 5'd0 || r == 5'd1);
    return 1'b0;
  endfunction

  // flags bit order: {gtz, ne, eq, gez, lez, ltz}
  function automatic logic m_cond(input logic [5:0] o, input logic [4:0] r, input logic [5:0] fl);
    case (o)
      6'd4: return fl[3];
      6'd5: return fl[4];
      6'd6: return fl[1];
      6'd7: return fl[5];
      6'd1: return (r == 5'd0) ? fl[0] : fl[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push(input logic ack, input logic [5:0] fl, input logic [25:0] e,
                               input string t);
    q_ack.push_back(ack); q_fl.push_back(fl); q_exp.push_back(e); q_tag.push_back(t);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rfl();
    return 6'($urandom);
  endfunction

  // Expand one instruction into expected cycles. fw/mw are the number of
  // wait cycles before mem_ack in FETCH/MEM; xfl are the flags in EXEC.
  // Outside FETCH/MEM mem_ack is random since it must be ignored there.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                       input int fw, input int mw, input logic [5:0] xfl);
    bit lg, wb;
    q_ack.delete(); q_fl.delete(); q_exp.delete(); q_tag.delete();
    for (int k = 0; k <= fw; k++)
      push(k == fw, rfl(), ov(1'b1, 1'b0, 1'b0, k == fw, k == fw, 2'd0, 6'h09, 6'h00,
                              1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
    if (o == 6'd2) begin
      push(rb(), rfl(), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h09, 6'h00,
                           1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0), "decode_j");
      return;
    end
    lg = m_legal(o, f, r);
    push(rb(), rfl(), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h09, 6'h00,
                         1'b0, 2'd3, 1'b0, 1'b0, 1'b0, !lg), lg ? "decode" : "decode_illegal");
    if (!lg) return;
    wb = 1'b0;
    if (o == 6'd0 && f == 6'h08) begin
      push(rb(), xfl, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 6'h00, 6'h00,
                         1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_jr");
    end else if (o == 6'd0) begin
      push(rb(), xfl, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o, f,
                         1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_r");
      wb = 1'b1;
    end else if (o >= 6'd8 && o <= 6'd15) begin
      push(rb(), xfl, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o, 6'h00,
                         1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0), "exec_i");
      wb = 1'b1;
    end else if (o == 6'h23 || o == 6'h2b) begin
      push(rb(), xfl, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, o, 6'h00,
                         1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0), "exec_mem");
      for (int k = 0; k <= mw; k++)
        push(k == mw, rfl(), ov(1'b1, o == 6'h2b, 1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 6'h00,
                                1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "mem");
      wb = (o == 6'h23);
    end else begin
      push(rb(), xfl, ov(1'b0, 1'b0, 1'b0, 1'b0, m_cond(o, r, xfl), 2'd1, o, 6'h00,
                         1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_branch");
    end
    if (wb)
      push(rb(), rfl(), ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 6'h00,
                           1'b0, 2'd0, 1'b1, o == 6'd0, o == 6'h23, 1'b0), "wb");
  endtask

  // Entered at posedge+1; asserts reset, checks outputs clear immediately,
  // releases, checks the IDLE cycle and leaves at posedge+1 in FETCH.
  task automatic reset_seq();
    rst_n = 1'b0;
    mem_ack = 1'b1;
    #1 check("rst_async", obs, 26'd0);
    @(posedge clk); #1;
    check("rst_hold", obs, 26'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", obs, 26'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                     input int abort_at);
    op = o; funct = f; rt = r;
    for (int i = 0; i < q_exp.size(); i++) begin
      mem_ack = q_ack[i];
      {gtz, ne, eq, gez, lez, ltz} = q_fl[i];
      @(negedge clk);
      check(q_tag[i], obs, q_exp[i]);
      if (i == abort_at) begin
        #1 reset_seq();
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                       input int fw, input int mw, input logic [5:0] xfl, input int abort_at);
    build(o, f, r, fw, mw, xfl);
    $display("instr op=%h funct=%h rt=%0d fw=%0d mw=%0d cycles=%0d abort=%0d",
             o, f, r, fw, mw, q_exp.size(), abort_at);
    run(o, f, r, abort_at);
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 9))
      0, 1, 2: return 6'h00;
      3:       return 6'h23;
      4:       return 6'h2b;
      5:       return 6'($urandom_range(8, 15));
      6:       return 6'($urandom_range(4, 7));
      7:       return 6'h01;
      8:       return 6'h02;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] ok_fn[17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20, 6'h21,
                              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    if ($urandom_range(0, 3) == 0) return 6'($urandom);
    return ok_fn[$urandom_range(0, 16)];
  endfunction

  initial begin
    #2 reset_seq();
    // addu with ack on the 3rd FETCH cycle
    instr(6'h00, 6'h21, 5'd0, 2, 0, rfl(), -1);
    // lw with two MEM wait cycles
    instr(6'h23, 6'h00, 5'd0, 0, 2, rfl(), -1);
    // beq taken and not taken
    instr(6'h04, 6'h00, 5'd0, 0, 0, 6'b001000, -1);
    instr(6'h04, 6'h00, 5'd0, 0, 0, 6'b110111, -1);
    // bgez with gez=1 (taken or illegal depending on build)
    instr(6'h01, 6'h00, 5'd1, 0, 0, 6'b000100, -1);
    instr(6'h01, 6'h00, 5'd0, 1, 0, 6'b000001, -1);
    instr(6'h01, 6'h00, 5'd2, 0, 0, 6'b111111, -1);
    instr(6'h06, 6'h00, 5'd0, 0, 0, 6'b000010, -1);
    instr(6'h07, 6'h00, 5'd0, 0, 0, 6'b100000, -1);
    // sw with reset asserted during the first MEM cycle
    instr(6'h2b, 6'h00, 5'd0, 0, 3, rfl(), 3);
    // reset during a stalled FETCH
    instr(6'h00, 6'h21, 5'd0, 3, 0, rfl(), 1);
    // undecodable opcode, unsupported funct, j, jr, sw, I-type
    instr(6'h3f, 6'h00, 5'd0, 0, 0, rfl(), -1);
    instr(6'h00, 6'h01, 5'd0, 0, 0, rfl(), -1);
    instr(6'h02, 6'h00, 5'd0, 0, 0, rfl(), -1);
    instr(6'h00, 6'h08, 5'd0, 0, 0, rfl(), -1);
    instr(6'h2b, 6'h00, 5'd0, 0, 0, rfl(), -1);
    instr(6'h0d, 6'h00, 5'd0, 0, 0, rfl(), -1);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      int fw, mw, ab;
      o = rand_op();
      f = rand_funct();
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      build(o, f, 5'($urandom_range(0, 3)), fw, mw, rfl());
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, q_exp.size() - 1) : -1;
      instr(o, f, 5'(q_exp.size() > 0 ? $urandom_range(0, 3) : 0), fw, mw, rfl(), ab);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
